prio_rr_case_arbiter: RTL and testbench
=======================================

// Module: prio_rr_case_arbiter
// PURPOSE
//  N-channel registered arbiter generalising priority/unique case selection.
//  - Picks one requester per grant, by fixed priority or round robin.
//  - Holds the grant until the owner releases it.
//  - Flags and counts "unique violations": more than one request present
//    at the moment of arbitration.
//  - Sits between request sources (DMA/CSR masters) and a single shared resource.
// PARAMETERS
//  N      4  number of request channels (2..32)
//  MODE   0  0 = fixed priority (lowest index wins); 1 = round robin
//  CNT_W  8  width of saturating unique-violation counter
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  req        in   N           request vector, level-sensitive
//  rel        in   1           owner releases current grant (sampled only in GRANT)
//  gnt        out  N           one-hot grant, registered
//  gnt_idx    out  $clog2(N)   binary index of granted channel
//  gnt_vld    out  1           grant active
//  uniq_viol  out  1           1-cycle pulse: popcount(req)>1 at arbitration
//  viol_cnt   out  CNT_W       saturating count of uniq_viol pulses
//  busy_miss  out  1           1-cycle pulse: req from non-owner seen while in GRANT
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//    - gnt=0, gnt_idx=0, gnt_vld=0, uniq_viol=0, busy_miss=0, viol_cnt=0
//    - state=IDLE; RR pointer=0
//    - Applies mid-grant too: the grant is dropped at that edge.
//  States: IDLE, GRANT.
//  IDLE
//    - req==0: stay; outputs hold reset values.
//    - req!=0: at next edge go to GRANT.
//      - gnt=onehot(sel), gnt_idx=sel, gnt_vld=1.
//      - Latency req->gnt_vld is 1 cycle.
//  Selection
//    - MODE=0: sel = lowest set index of req.
//    - MODE=1: sel = first set index searching ptr, ptr+1, ... N-1, 0, ... ptr-1
//      (wraps modulo N).
//      - On each grant, ptr <= (sel+1) mod N; sel=N-1 wraps ptr to 0.
//  uniq_viol
//    - Registered with the grant; =1 for exactly the first GRANT cycle when
//      popcount(req)>1 at arbitration.
//    - viol_cnt increments on that edge; it saturates at 2^CNT_W-1 (no wrap).
//  GRANT
//    - gnt/gnt_idx held constant regardless of req changes.
//    - Owner dropping req does NOT release the grant; only rel does.
//    - busy_miss=1 in any GRANT cycle where (req & ~gnt)!=0, registered
//      (visible next cycle).
//    - rel=1: next edge -> IDLE with gnt=0, gnt_vld=0, gnt_idx holds last value.
//    - New arbitration is earliest one cycle later (1 idle cycle between grants).
//  Other edges
//    - rel in IDLE is ignored.
//    - req and rel in same cycle as rst: rst wins.
//  X handling: sim-only assertion that req is never X in IDLE; no functional X path.
//  Assertions
//    - $onehot0(gnt)
//    - gnt_vld == |gnt
//    - gnt_idx matches gnt while gnt_vld=1
// TESTING (N=4, CNT_W=2)
//  T1 MODE=0: req=0100 -> next cycle gnt=0100, gnt_idx=2, gnt_vld=1, uniq_viol=0;
//     rel=1 -> gnt=0, gnt_vld=0.
//  T2 MODE=0: req=1010 -> gnt=0010, uniq_viol=1 one cycle, viol_cnt=1;
//     a further 4 multi-request grants -> viol_cnt stays 3.
//  T3 MODE=1: req=1111 held, release each grant -> grants 0001,0010,0100,1000,0001
//     (wrap); each grant separated by 1 idle cycle.
//  T4 MODE=1, ptr=3: req=0011 -> gnt=0001 (wrap search), ptr becomes 1.
//  T5 Grant hold: gnt=0010, drop req, raise req[3] -> gnt stays 0010;
//     busy_miss=1 next cycle; rel=1 -> IDLE, then gnt=1000.
//  T6 Reset mid-grant: gnt=0100, assert rst one cycle -> all outputs and
//     viol_cnt 0 next edge; first grant after reset in MODE=1 starts at ptr=0.

Source files
------------

// File: rtl/prio_rr_case_arbiter.sv
// Registered N-channel arbiter: fixed-priority or round-robin selection, grant held
// until released, with multi-request ("unique violation") flagging and counting.
module prio_rr_case_arbiter #(
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rel,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             uniq_viol,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             busy_miss
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               uv_q, uv_d;
    logic               bm_q, bm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               found;
    logic               multi_req;

    // Search starts at the pointer in round-robin mode, at index 0 otherwise;
    // the first requester hit along the (wrapping) search order wins.
    always_comb begin
        sel_idx  = '0;
        cand_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (MODE == 1) begin
                cand_idx = IDX_W'((int'(ptr_q) + i) % N);
            end else begin
                cand_idx = IDX_W'(i);
            end
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    assign multi_req = |(req & (req - N'(1)));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        uv_d    = 1'b0;
        bm_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << sel_idx;
                    idx_d   = sel_idx;
                    uv_d    = multi_req;
                    if (multi_req && (cnt_q != '1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (MODE == 1) begin
                        ptr_d = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + 1'b1;
                    end
                end
            end
            GRANT: begin
                // Grant is sticky: only rel ends it, whatever happens on req.
                bm_d = |(req & ~gnt_q);
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            uv_q    <= 1'b0;
            bm_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            uv_q    <= uv_d;
            bm_q    <= bm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_vld   = (state_q == GRANT);
    assign uniq_viol = uv_q;
    assign viol_cnt  = cnt_q;
    assign busy_miss = bm_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q));
            assert (gnt_vld == (|gnt_q));
            if (gnt_vld) assert (gnt_q[idx_q]);
            if (state_q == IDLE) assert (!$isunknown(req));
        end
    end
`endif

endmodule

// File: tb/tb_prio_rr_case_arbiter.sv
// Bench for prio_rr_case_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are checked against a transaction-level reference model.
module tb_prio_rr_case_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;

    logic [3:0] gnt_s [2];
    logic [1:0] idx_s [2];
    logic       vld_s [2];
    logic       uv_s  [2];
    logic [1:0] cnt_s [2];
    logic       bm_s  [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance (0 = fixed priority, 1 = round robin)
    bit m_gr  [2];
    int m_own [2];
    int m_idx [2];
    int m_ptr [2];
    int m_cnt [2];
    bit m_uv  [2];
    bit m_bm  [2];

    prio_rr_case_arbiter #(.N(4), .MODE(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt_s[0]), .gnt_idx(idx_s[0]), .gnt_vld(vld_s[0]),
        .uniq_viol(uv_s[0]), .viol_cnt(cnt_s[0]), .busy_miss(bm_s[0])
    );

    prio_rr_case_arbiter #(.N(4), .MODE(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt_s[1]), .gnt_idx(idx_s[1]), .gnt_vld(vld_s[1]),
        .uniq_viol(uv_s[1]), .viol_cnt(cnt_s[1]), .busy_miss(bm_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(int k, logic [3:0] r);
        int start;
        start = (k == 1) ? m_ptr[k] : 0;
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return 0;
    endfunction

    function automatic logic [3:0] exp_gnt(int k);
        logic [3:0] one;
        one = 4'b0001;
        return m_gr[k] ? (one << m_own[k]) : 4'b0000;
    endfunction

    // Apply one cycle of inputs, advance the model, then wait until just past the edge.
    task automatic drive(input logic [3:0] r, input logic l, input logic rs);
        logic [3:0] one;
        bit nbm;
        int sel;
        one = 4'b0001;
        req = r;
        rel = l;
        rst = rs;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                m_gr[k] = 0; m_own[k] = 0; m_idx[k] = 0; m_ptr[k] = 0;
                m_cnt[k] = 0; m_uv[k] = 0; m_bm[k] = 0;
            end else begin
                nbm = m_gr[k] && ((r & ~(one << m_own[k])) != 4'b0000);
                m_uv[k] = 0;
                if (m_gr[k]) begin
                    if (l) m_gr[k] = 0;
                end else if (r != 4'b0000) begin
                    sel = pick(k, r);
                    m_gr[k]  = 1;
                    m_own[k] = sel;
                    m_idx[k] = sel;
                    m_uv[k]  = ($countones(r) > 1);
                    if (m_uv[k] && m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
                    if (k == 1) m_ptr[k] = (sel + 1) % 4;
                end
                m_bm[k] = nbm;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (gnt_s[k] !== 4'b0000) begin failures++; $display("FAIL reset_gnt[%0d] got=%b exp=0000", k, gnt_s[k]); end
            checks++; if (idx_s[k] !== 2'd0) begin failures++; $display("FAIL reset_idx[%0d] got=%0d exp=0", k, idx_s[k]); end
            checks++; if (vld_s[k] !== 1'b0 || uv_s[k] !== 1'b0 || bm_s[k] !== 1'b0) begin failures++; $display("FAIL reset_flags[%0d] got vld=%b uv=%b bm=%b exp=0", k, vld_s[k], uv_s[k], bm_s[k]); end
            checks++; if (cnt_s[k] !== 2'd0) begin failures++; $display("FAIL reset_cnt[%0d] got=%0d exp=0", k, cnt_s[k]); end
        end
    endtask

    task automatic test_single_request();
        drive(4'b0100, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0100) begin failures++; $display("FAIL t1_gnt got=%b exp=0100", gnt_s[0]); end
        checks++; if (idx_s[0] !== 2'd2) begin failures++; $display("FAIL t1_idx got=%0d exp=2", idx_s[0]); end
        checks++; if (vld_s[0] !== 1'b1 || uv_s[0] !== 1'b0) begin failures++; $display("FAIL t1_vld_uv got vld=%b uv=%b exp vld=1 uv=0", vld_s[0], uv_s[0]); end
        drive(4'b0000, 1'b1, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0000 || vld_s[0] !== 1'b0) begin failures++; $display("FAIL t1_release got gnt=%b vld=%b exp gnt=0000 vld=0", gnt_s[0], vld_s[0]); end
        checks++; if (idx_s[0] !== 2'd2) begin failures++; $display("FAIL t1_idx_hold got=%0d exp=2", idx_s[0]); end
    endtask

    task automatic test_uniq_viol();
        drive(4'b1010, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0010) begin failures++; $display("FAIL t2_gnt got=%b exp=0010", gnt_s[0]); end
        checks++; if (uv_s[0] !== 1'b1 || cnt_s[0] !== 2'd1) begin failures++; $display("FAIL t2_viol got uv=%b cnt=%0d exp uv=1 cnt=1", uv_s[0], cnt_s[0]); end
        drive(4'b1010, 1'b0, 1'b0);
        checks++; if (uv_s[0] !== 1'b0) begin failures++; $display("FAIL t2_uv_pulse got=%b exp=0", uv_s[0]); end
        checks++; if (bm_s[0] !== 1'b1) begin failures++; $display("FAIL t2_busy_miss got=%b exp=1", bm_s[0]); end
        drive(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b0, 1'b0);
            drive(4'b0000, 1'b1, 1'b0);
        end
        checks++; if (cnt_s[0] !== 2'd3) begin failures++; $display("FAIL t2_sat_cnt0 got=%0d exp=3", cnt_s[0]); end
        checks++; if (cnt_s[1] !== 2'd3) begin failures++; $display("FAIL t2_sat_cnt1 got=%0d exp=3", cnt_s[1]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, 1'b0);
            checks++; if (gnt_s[1] !== seq[i]) begin failures++; $display("FAIL t3_rr_gnt[%0d] got=%b exp=%b", i, gnt_s[1], seq[i]); end
            drive(4'b1111, 1'b1, 1'b0);
            checks++; if (vld_s[1] !== 1'b0 || gnt_s[1] !== 4'b0000) begin failures++; $display("FAIL t3_rr_idle[%0d] got vld=%b gnt=%b exp vld=0 gnt=0000", i, vld_s[1], gnt_s[1]); end
        end
    endtask

    task automatic test_rr_wrap();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0100, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b0011, 1'b0, 1'b0);
        checks++; if (gnt_s[1] !== 4'b0001) begin failures++; $display("FAIL t4_wrap_gnt got=%b exp=0001", gnt_s[1]); end
        checks++; if (gnt_s[0] !== 4'b0001) begin failures++; $display("FAIL t4_fixed_gnt got=%b exp=0001", gnt_s[0]); end
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1101, 1'b0, 1'b0);
        checks++; if (gnt_s[1] !== 4'b0100) begin failures++; $display("FAIL t4_ptr1_gnt got=%b exp=0100", gnt_s[1]); end
        checks++; if (gnt_s[0] !== 4'b0001) begin failures++; $display("FAIL t4_fixed2_gnt got=%b exp=0001", gnt_s[0]); end
        drive(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_grant_hold();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0010, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0010) begin failures++; $display("FAIL t5_gnt got=%b exp=0010", gnt_s[0]); end
        drive(4'b1000, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0010 || vld_s[0] !== 1'b1) begin failures++; $display("FAIL t5_hold got gnt=%b vld=%b exp gnt=0010 vld=1", gnt_s[0], vld_s[0]); end
        checks++; if (bm_s[0] !== 1'b1) begin failures++; $display("FAIL t5_busy_miss got=%b exp=1", bm_s[0]); end
        drive(4'b1000, 1'b1, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0000 || vld_s[0] !== 1'b0) begin failures++; $display("FAIL t5_release got gnt=%b vld=%b exp gnt=0000 vld=0", gnt_s[0], vld_s[0]); end
        drive(4'b1000, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b1000 || idx_s[0] !== 2'd3) begin failures++; $display("FAIL t5_regrant got gnt=%b idx=%0d exp gnt=1000 idx=3", gnt_s[0], idx_s[0]); end
        drive(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_grant();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1100, 1'b0, 1'b0);
        checks++; if (gnt_s[0] !== 4'b0100 || cnt_s[0] !== 2'd1) begin failures++; $display("FAIL t6_pre got gnt=%b cnt=%0d exp gnt=0100 cnt=1", gnt_s[0], cnt_s[0]); end
        drive(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (gnt_s[k] !== 4'b0000 || vld_s[k] !== 1'b0 || idx_s[k] !== 2'd0 || cnt_s[k] !== 2'd0) begin failures++; $display("FAIL t6_rst[%0d] got gnt=%b vld=%b idx=%0d cnt=%0d exp all 0", k, gnt_s[k], vld_s[k], idx_s[k], cnt_s[k]); end
        end
        drive(4'b1010, 1'b0, 1'b0);
        checks++; if (gnt_s[1] !== 4'b0010) begin failures++; $display("FAIL t6_rr_ptr0 got=%b exp=0010", gnt_s[1]); end
        drive(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic l, rs;
        drive(4'b0000, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            l  = ($urandom_range(0, 9) < 3);
            rs = ($urandom_range(0, 49) == 0);
            drive(r, l, rs);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (gnt_s[k] !== exp_gnt(k) || vld_s[k] !== m_gr[k] || idx_s[k] !== 2'(m_idx[k])
                    || uv_s[k] !== m_uv[k] || cnt_s[k] !== 2'(m_cnt[k]) || bm_s[k] !== m_bm[k]) begin
                    failures++;
                    $display("FAIL rand[%0d] inst=%0d got gnt=%b vld=%b idx=%0d uv=%b cnt=%0d bm=%b exp gnt=%b vld=%b idx=%0d uv=%b cnt=%0d bm=%b",
                             n, k, gnt_s[k], vld_s[k], idx_s[k], uv_s[k], cnt_s[k], bm_s[k],
                             exp_gnt(k), m_gr[k], m_idx[k], m_uv[k], m_cnt[k], m_bm[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_request();
        test_uniq_viol();
        test_round_robin();
        test_rr_wrap();
        test_grant_hold();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
